// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared direction type, direction constants, the opposite
//               direction rule and the reset direction for the snake game.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    // The snake starts moving right after reset.
    localparam dir_t DIR_RESET = DIR_RIGHT;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0.
    function automatic dir_t opposite_dir(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
// Module      : debounce
// Description : 2-flop synchronizer followed by a stable-level counter.
//               Emits the debounced level and a one-cycle pulse on each
//               0->1 transition of that level.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             w_differ;
    logic             w_toggle;

    assign w_differ = (r_sync2 != r_level);
    assign w_toggle = w_differ && (r_cnt == c_LAST);

    // Synchronize the raw switch, count disagreeing cycles, flip when stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            r_press <= w_toggle && !r_level;
            if (!w_differ || w_toggle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_toggle) begin
                r_level <= ~r_level;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/direction_input.sv
`default_nettype none
// ============================================================================
// Module      : direction_input
// Description : Debounces four direction switches, arbitrates press events,
//               rejects same/reverse requests and commits at most one new
//               direction per movement step.
// Revision    : 1.0 - initial release
// ============================================================================
module direction_input
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_up,
    input  logic       sw_down,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       refresh_tick,
    output dir_t       dir,
    output logic       dir_strobe,
    output logic [3:0] pressed
);

    // Bit order {up,down,left,right} throughout.
    logic [3:0] w_sw;
    logic [3:0] w_level;
    logic [3:0] w_press;

    assign w_sw = {sw_up, sw_down, sw_left, sw_right};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sw
            debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .i_sw    (w_sw[gi]),
                .o_level (w_level[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    dir_t r_dir;
    logic r_strobe;
    dir_t r_pend;
    logic r_pend_v;
    dir_t w_req;
    dir_t w_ref;
    logic w_accept;

    // Pick one press by priority and test it against the reference direction.
    always_comb begin
        w_req    = DIR_UP;
        w_ref    = r_pend_v ? r_pend : r_dir;
        w_accept = 1'b0;
        if (w_press[3]) begin
            w_req = DIR_UP;
        end else if (w_press[2]) begin
            w_req = DIR_DOWN;
        end else if (w_press[1]) begin
            w_req = DIR_LEFT;
        end else begin
            w_req = DIR_RIGHT;
        end
        if ((|w_press) && (w_req != w_ref) && (w_req != opposite_dir(w_ref))) begin
            w_accept = 1'b1;
        end
    end

    // Pending register plus commit on the movement tick; a press accepted in
    // the same cycle as a commit becomes the next pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir    <= DIR_RESET;
            r_strobe <= 1'b0;
            r_pend   <= DIR_RESET;
            r_pend_v <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (refresh_tick && r_pend_v) begin
                r_dir    <= r_pend;
                r_strobe <= 1'b1;
                r_pend_v <= 1'b0;
            end
            if (w_accept) begin
                r_pend   <= w_req;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign dir        = r_dir;
    assign dir_strobe = r_strobe;
    assign pressed    = w_level;

endmodule
`default_nettype wire

// File: tb/tb_direction_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_direction_input
// Description : Self-checking bench for direction_input with a behavioural
//               reference model, directed scenarios and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_direction_input;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = 4'b0000;   // {up,down,left,right}
    logic       tick = 1'b0;
    logic [1:0] dir;
    logic       dir_strobe;
    logic [3:0] pressed;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    direction_input #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_up        (sw[3]),
        .sw_down      (sw[2]),
        .sw_left      (sw[1]),
        .sw_right     (sw[0]),
        .refresh_tick (tick),
        .dir          (dir),
        .dir_strobe   (dir_strobe),
        .pressed      (pressed)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Switch k delayed through two sync stages, then accepted once it has
    // disagreed with the held level for DEB consecutive cycles.
    logic [1:0] m_pipe [4];
    int         m_run  [4];
    logic [3:0] m_level;
    logic [3:0] m_press;
    logic [1:0] m_dir;
    logic       m_strobe;
    logic [1:0] m_pend;
    bit         m_pv;

    function automatic logic [1:0] reverse_of(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;  // UP    <-> DOWN
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;  // LEFT  <-> RIGHT
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [1:0] ref_d;
        logic [1:0] req;
        bit         any;
        logic [3:0] nxt_press;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_pipe[k] = 2'b00;
                m_run[k]  = 0;
            end
            m_level  = 4'b0;
            m_press  = 4'b0;
            m_dir    = 2'b11;
            m_strobe = 1'b0;
            m_pend   = 2'b11;
            m_pv     = 1'b0;
        end else begin
            // direction decision from the press pulses of this cycle
            ref_d = m_pv ? m_pend : m_dir;
            any   = 1'b0;
            req   = 2'b00;
            for (int p = 3; p >= 0; p--) begin
                if (!any && m_press[p]) begin
                    any = 1'b1;
                    req = 2'(3 - p);
                end
            end
            m_strobe = 1'b0;
            if (tick && m_pv) begin
                m_dir    = m_pend;
                m_strobe = 1'b1;
                m_pv     = 1'b0;
            end
            if (any && req != ref_d && req != reverse_of(ref_d)) begin
                m_pend = req;
                m_pv   = 1'b1;
            end
            // debouncing
            nxt_press = 4'b0;
            for (int k = 0; k < 4; k++) begin
                if (m_pipe[k][1] != m_level[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == DEB) begin
                    m_run[k]   = 0;
                    m_level[k] = ~m_level[k];
                    nxt_press[k] = m_level[k];
                end
                m_pipe[k] = {m_pipe[k][0], sw[k]};
            end
            m_press = nxt_press;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cycle", {dir, dir_strobe, 1'b0, pressed}, {m_dir, m_strobe, 1'b0, m_level});
            if (dir_strobe) strobe_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sw   = 4'b0;
        tick = 1'b0;
        cycles(2);
        rst = 1'b0;
        strobe_cnt = 0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
    endtask

    initial begin
        cycles(1);
        started = 1'b1;
        do_reset();
        chk("reset_state", {dir, dir_strobe, 1'b0, pressed}, {2'b11, 1'b0, 1'b0, 4'b0000});

        // Held UP: debounced after 6 cycles, committed on the tick.
        sw[3] = 1'b1;
        cycles(6);
        chk("up_pressed_6", {4'b0, pressed}, 8'h08);
        cycles(4);
        tick = 1'b1;
        cycles(1);
        tick = 1'b0;
        chk("up_dir", {6'b0, dir}, 8'h00);
        chk("up_strobe", {7'b0, dir_strobe}, 8'h01);
        cycles(1);
        chk("up_strobe_one", {7'b0, dir_strobe}, 8'h00);
        sw[3] = 1'b0;
        cycles(8);

        // LEFT while moving RIGHT is a reversal and is dropped.
        do_reset();
        sw[1] = 1'b1;
        cycles(10);
        pulse_tick();
        cycles(2);
        chk("left_rev_dir", {6'b0, dir}, 8'h03);
        chk("left_rev_nostrobe", 8'(strobe_cnt), 8'h00);

        // Short DOWN glitch never reaches the debounced level.
        do_reset();
        sw[2] = 1'b1;
        cycles(3);
        sw[2] = 1'b0;
        cycles(10);
        pulse_tick();
        cycles(2);
        chk("glitch_pressed", {4'b0, pressed}, 8'h00);
        chk("glitch_dir", {6'b0, dir}, 8'h03);
        chk("glitch_nostrobe", 8'(strobe_cnt), 8'h00);

        // UP then DOWN before one tick: DOWN reverses pending UP.
        do_reset();
        sw[3] = 1'b1;
        cycles(8);
        sw[3] = 1'b0;
        sw[2] = 1'b1;
        cycles(10);
        pulse_tick();
        chk("updown_dir", {6'b0, dir}, 8'h00);
        sw[2] = 1'b0;
        cycles(10);
        pulse_tick();
        cycles(2);
        chk("updown_dir2", {6'b0, dir}, 8'h00);
        chk("updown_one_strobe", 8'(strobe_cnt), 8'h01);

        // Simultaneous UP and DOWN: UP has priority.
        do_reset();
        sw[3] = 1'b1;
        sw[2] = 1'b1;
        cycles(10);
        pulse_tick();
        chk("simul_up_wins", {6'b0, dir}, 8'h00);
        sw = 4'b0;
        cycles(8);

        // Pending UP wiped by a reset pulse.
        do_reset();
        sw[3] = 1'b1;
        cycles(10);
        sw[3] = 1'b0;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        strobe_cnt = 0;
        pulse_tick();
        cycles(2);
        chk("rst_pending_dir", {6'b0, dir}, 8'h03);
        chk("rst_pending_nostrobe", 8'(strobe_cnt), 8'h00);

        // Random phase: switch levels hold for random spans, random ticks.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) == 0) sw[k] = ~sw[k];
            end
            tick = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 799) == 0);
            cycles(1);
        end
        rst  = 1'b0;
        tick = 1'b0;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/direction_input.md
DIRECTION_INPUT -- requirements
Module: direction_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable clk cycles required to accept a switch level change (10 ms at 25 MHz).
REQ-002 Parameter CNT_W, default 18, is the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single clock (the VGA pixel clock); all logic is on the rising edge.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 sw_up, sw_down, sw_left, sw_right  input  1 each  raw asynchronous player switches; 1 means pressed.
REQ-006 refresh_tick  input  1  single-cycle strobe in the clk domain marking one snake movement step.
REQ-007 dir  output  2  committed direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT.
REQ-008 dir_strobe  output  1  one-cycle pulse on the cycle dir takes a new value.
REQ-009 pressed  output  4  debounced switch levels {up,down,left,right} for status LEDs.

Function
REQ-010 Each switch SHALL pass through a 2-flop synchronizer before any other logic; the synchronizer adds 2 cycles of latency.
REQ-011 Each synchronized switch SHALL have its own counter that clears whenever the synchronized level equals the debounced level and otherwise increments.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 while the levels differ, the debounced level SHALL toggle on the next edge and the counter SHALL clear; a glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
REQ-013 A press event SHALL be a one-cycle pulse generated on the rising edge (0->1) of a debounced level; releases generate no event.
REQ-014 When several press events occur in the same cycle, exactly one SHALL be taken, with priority UP > DOWN > LEFT > RIGHT.
REQ-015 A press SHALL be checked against the reference direction:
  - reference = pending value if pending_valid, else dir;
  - in a refresh_tick cycle, reference = pending value if pending_valid (being committed), else dir.
REQ-016 A press equal to the reference, or opposite to it (opposite = reference XOR 2'b01), SHALL be discarded; otherwise it is stored as pending and sets pending_valid.
REQ-017 A later accepted press SHALL overwrite pending (last wins) until commit.
REQ-018 On a cycle with refresh_tick=1 and pending_valid=1, the next edge SHALL load dir with the pending value, clear pending_valid and assert dir_strobe for exactly one cycle; refresh_tick with pending_valid=0 SHALL leave dir unchanged and dir_strobe low.
REQ-019 A press accepted in a refresh_tick cycle SHALL become the new pending and commit no earlier than the next refresh_tick.
REQ-020 At most one direction change SHALL be committed per refresh_tick, so the snake can never reverse onto itself within one step.
REQ-021 Consecutive refresh_tick cycles SHALL be handled independently, with no pulse merging.

Reset
REQ-022 While rst=1 at an edge: dir=11 (RIGHT), dir_strobe=0, pressed=0000, pending_valid=0, all counters and synchronizer flops =0.
REQ-023 Reset asserted mid-debounce or with a pending press SHALL discard all in-progress state; no dir_strobe SHALL follow reset release until a new press is fully debounced.
REQ-024 A switch already held at reset release SHALL be debounced from 0 and produce one press event after 2+DEBOUNCE_CYCLES cycles.

Structure
REQ-025 Shared package snake_pkg SHALL hold:
  - the 2-bit direction type and constants DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT;
  - the opposite-direction rule (XOR 01);
  - the reset direction constant.
REQ-026 The synchronizer plus debounce counter SHALL be a sub-module named debounce, instantiated four times; press arbitration and the pending/commit register stay in direction_input.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 Reset, hold sw_up=1 for 10 cycles, then pulse refresh_tick -> pressed=1000 after 6 cycles, dir=00 with dir_strobe high one cycle after the tick.
REQ-028 With dir=11, a clean sw_left press then refresh_tick -> press discarded as opposite: dir stays 11, dir_strobe never asserts.
REQ-029 sw_down 3-cycle glitch, then refresh_tick -> pressed stays 0000, no dir change.
REQ-030 With dir=11, debounced presses of UP then DOWN before one tick -> DOWN is discarded as opposite of pending UP, dir=00 after the tick; a second tick gives no strobe.
REQ-031 With dir=11, sw_up and sw_down debounce in the same cycle -> UP wins, dir=00 on the next tick.
REQ-032 Pending UP present, rst pulsed one cycle, then refresh_tick -> dir=11, dir_strobe=0.
